seg7_scan_driver: RTL and testbench
===================================

# seg7_scan_driver

Time-multiplexed driver for an N-digit common-anode 7-segment display. It latches a packed hex word and scans one digit per refresh slot, decoding each nibble to active-low segments. Scanning uses a programmable prescaler with an inter-digit blanking gap to suppress ghosting. New data is committed only at frame boundaries, so a display never shows a mix of old and new digits. It sits between the Hamming encoder/decoder datapath and the board's display pins.

## Interface
- N_DIGITS, 4, number of digits scanned (1..8)
- REFRESH_DIV, 27000, clock cycles per digit slot (>= 2)
- BLANK_CYC, 16, cycles at the start of each slot with all anodes off (0 <= BLANK_CYC < REFRESH_DIV)
- clk  input  1  system clock; all state on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- data  input  4*N_DIGITS  packed hex digits; digit 0 (rightmost) = data[3:0]
- load  input  1  single-cycle strobe: capture data into pending register
- digit_en  input  N_DIGITS  per-digit enable; 0 forces that digit dark (sampled live)
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low (0 = lit)
- an  output  N_DIGITS  digit anodes, active-low (0 = digit on)
- pending  output  1  1 while loaded data awaits frame-boundary commit
- frame_start  output  1  one-cycle pulse when digit index wraps to 0

## Operation
- Prescaler cnt counts 0..REFRESH_DIV-1 and wraps. tick = (cnt == REFRESH_DIV-1).
- Digit index idx increments on tick, with wrap N_DIGITS-1 -> 0. A frame is N_DIGITS slots.
- Load: when load=1, pend_reg <= data and pend_v <= 1. Load is always accepted; the latest load wins.
- Commit: on a tick where idx wraps to 0 and pend_v=1, shadow <= pend_reg and pend_v <= 0.
- Load and commit in the same cycle: the commit takes the old pend_reg. The new data goes to pend_reg and pend_v stays 1, so it commits at the next frame.
- Digit visible when cnt >= BLANK_CYC and digit_en[idx]=1 (and not LZB-blanked; see Configuration).
- When the digit is visible: an = ~(1 << idx) and seg = hex decode of shadow[4*idx +: 4]. Otherwise an = all 1s and seg = 7'b1111111.
- Hex decode table (seg, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Only one anode may ever be low at a time.

## Timing
- Reset values: cnt=0, idx=0, shadow=0, pend_reg=0, pend_v=0, an=all 1s, seg=7'b1111111, pending=0, frame_start=0.
- seg, an and frame_start are registered: they reflect the cnt/idx state of the previous cycle (1-cycle latency).
- pending is driven directly from pend_v and rises the cycle after load.
- frame_start pulses for exactly one cycle, the cycle after the wrapping tick. It coincides with the first cycle in which the new shadow is in effect.
- Worst-case load-to-display latency: N_DIGITS*REFRESH_DIV + BLANK_CYC + 1 cycles.
- Reset asserted mid-frame: all state returns immediately to reset values. After release, scanning restarts at idx=0, cnt=0, and pending data is discarded.
- digit_en changes take effect on the next registered output cycle, without waiting for a frame boundary.
- Prescaler width: $clog2(REFRESH_DIV). Index width: $clog2(N_DIGITS) (minimum 1).

## Configuration
- SEG7_LZB_EN defined: leading-zero blanking is enabled.
  - Digits above the most-significant nonzero nibble of shadow are dark.
  - Digit 0 is never blanked, so shadow=0 shows a single "0".
  - The blank mask is computed from shadow and changes only at commit.
- SEG7_LZB_EN undefined: no leading-zero logic is synthesised, and all enabled digits are shown, including zeros.

## Structure
- Package seg7_pkg:
  - SEG_OFF = 7'b1111111
  - the 16-entry hex segment table as a localparam array
  - function hex2seg(logic [3:0]) returning logic [6:0]
- Sub-module seg7_hex_dec: combinational nibble-to-segment decoder using seg7_pkg. The top instantiates one copy after the digit mux.
- Top seg7_scan_driver holds the prescaler, index counter, pending/shadow registers, blanking and output registers.

## Test plan
Bench parameters for all scenarios: N_DIGITS=4, REFRESH_DIV=8, BLANK_CYC=2.
- Reset: hold rst_n=0 with data=16'h1234, load=1. Required: an=4'b1111, seg=7'b1111111, pending=0. After release, frame 0 shows "0000" (LZB off).
- Load 16'h12AF, then wait one frame.
  - Required: pending=1 until frame_start.
  - Per slot, in order: an=1110/seg=0001110, then 1101/0001000, then 1011/0100100, then 0111/1111001.
  - an=1111 during the first 2 cycles of each slot.
- Load 16'h1111, then 16'h2222 mid-frame. Required: only 2222 is committed at the next frame_start, with no mixed-digit frame.
- Load on the exact wrapping-tick cycle. Required: the old pend_reg is committed, pending stays 1, and the new value appears one frame later.
- digit_en=4'b1010 with shadow=16'h8888. Required: digits 0 and 2 are never lit (an bits 0 and 2 stay 1), and digits 1 and 3 show 0000000.
- SEG7_LZB_EN with load 16'h0050. Required: digits 3 and 2 stay dark, and digits 1 and 0 show "5" and "0". With load 16'h0000, only digit 0 shows "0".

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types, constants and the hex-to-segment table for the 7-segment scan driver.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package seg7_pkg;

  // Segment vector ordered {g,f,e,d,c,b,a}, active-low (0 = lit).
  typedef logic [6:0] seg_t;

  // All segments dark.
  localparam seg_t SEG_OFF = 7'b1111111;

  // Hex glyphs 0..F, active-low. Lower-case b and d keep them distinct from 8 and 0.
  localparam seg_t HEX_SEG [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b1000110,  // C
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

  // Look up the active-low glyph for one nibble.
  function automatic seg_t hex2seg(input logic [3:0] nib);
    return HEX_SEG[nib];
  endfunction

endpackage

// File: rtl/seg7_hex_dec.sv
// Combinational nibble-to-segment decoder (active-low {g,f,e,d,c,b,a}).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; output follows input continuously.
module seg7_hex_dec
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output seg_t       seg
);

  assign seg = hex2seg(nib);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit common-anode 7-segment driver; commits new data only at frame boundaries.
// Latency: seg/an/frame_start registered (1 cycle after scan state); pending is direct from the pending flag.
// Backpressure: none; load is always accepted and the latest load wins. Build option: SEG7_LZB_EN enables leading-zero blanking.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 27000,
  parameter int BLANK_CYC   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] data,
  input  logic                  load,
  input  logic [N_DIGITS-1:0]   digit_en,
  output logic [6:0]            seg,
  output logic [N_DIGITS-1:0]   an,
  output logic                  pending,
  output logic                  frame_start
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int DW = 4 * N_DIGITS;

  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIGITS - 1);

  // Scan state.
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic          tick;
  logic          wrap;
  logic          commit;

  // Data path: pending register holds the latest load, shadow is what is displayed.
  logic [DW-1:0] pend_reg;
  logic          pend_v;
  logic [DW-1:0] shadow;

  // Current-digit selection and visibility.
  logic [3:0]          nib;
  logic                en_cur;
  logic                lzb_cur;
  logic                blank_done;
  logic                visible;
  seg_t                seg_dec;
  logic [N_DIGITS-1:0] an_nxt;
  logic [N_DIGITS-1:0] lzb_dark;

  assign tick   = (cnt == CNT_LAST);
  assign wrap   = tick && (idx == IDX_LAST);
  // A commit only happens on the tick that returns the index to digit 0.
  assign commit = wrap && pend_v;

  // Prescaler: counts one refresh slot and wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Digit index: advances once per slot, wraps at the last digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (tick) begin
      idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
    end
  end

  // Pending capture: a same-cycle load overrides the clear so the new word waits for the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_reg <= '0;
      pend_v   <= 1'b0;
    end else if (load) begin
      pend_reg <= data;
      pend_v   <= 1'b1;
    end else if (commit) begin
      pend_v   <= 1'b0;
    end
  end

  // Shadow commit: takes the pre-edge pend_reg, so a coincident load is not shown mid-frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
    end else if (commit) begin
      shadow <= pend_reg;
    end
  end

`ifdef SEG7_LZB_EN
  // Leading-zero mask: a digit is dark when it and every digit above it are zero; digit 0 always shows.
  always_comb begin
    logic seen;
    seen     = 1'b0;
    lzb_dark = '0;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      seen        = seen | (shadow[4*i +: 4] != 4'h0);
      lzb_dark[i] = !seen;
    end
  end
`else
  // No leading-zero blanking in this build: no digit is ever suppressed by value.
  assign lzb_dark = '0;
`endif

  // Digit mux: pick the nibble, live enable and blank flag for the digit being scanned.
  always_comb begin
    nib     = 4'h0;
    en_cur  = 1'b0;
    lzb_cur = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        nib     = shadow[4*i +: 4];
        en_cur  = digit_en[i];
        lzb_cur = lzb_dark[i];
      end
    end
  end

  // Inter-digit gap at the start of each slot keeps the previous digit from ghosting.
  assign blank_done = (cnt >= CNT_BLANK);
  assign visible    = blank_done && en_cur && !lzb_cur;

  seg7_hex_dec u_hex_dec (
    .nib (nib),
    .seg (seg_dec)
  );

  // Anode pattern: at most the scanned digit is pulled low.
  always_comb begin
    an_nxt = '1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (visible && (idx == IW'(i))) begin
        an_nxt[i] = 1'b0;
      end
    end
  end

  // Output registers: one cycle behind the scan state, glitch-free to the pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg         <= SEG_OFF;
      an          <= '1;
      frame_start <= 1'b0;
    end else begin
      seg         <= visible ? seg_dec : SEG_OFF;
      an          <= an_nxt;
      frame_start <= wrap;
    end
  end

  assign pending = pend_v;

  // Never drive two anodes at once.
  a_one_anode : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(~an));

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver with N_DIGITS=4, REFRESH_DIV=8, BLANK_CYC=2.
// The reference derives slot and position from a free-running cycle count since reset.
// Inputs are driven 1 time unit after the falling edge; outputs are compared on the falling edge.
module tb_seg7_scan_driver;

  localparam int N = 4;
  localparam int R = 8;
  localparam int B = 2;

  localparam logic [6:0] DEC [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] data = 16'h0;
  logic        load = 1'b0;
  logic [3:0]  digit_en = 4'hF;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        pending;
  logic        frame_start;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .N_DIGITS    (N),
    .REFRESH_DIV (R),
    .BLANK_CYC   (B)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data        (data),
    .load        (load),
    .digit_en    (digit_en),
    .seg         (seg),
    .an          (an),
    .pending     (pending),
    .frame_start (frame_start)
  );

  // Reference state.
  int          m_k = 0;
  logic [15:0] m_shadow = 16'h0;
  logic [15:0] m_pend_val = 16'h0;
  logic        m_pend_v = 1'b0;
  logic [3:0]  e_an = 4'hF;
  logic [6:0]  e_seg = 7'h7F;
  logic        e_fs = 1'b0;

  function automatic bit lz_dark(logic [15:0] sh, int slot);
`ifdef SEG7_LZB_EN
    return (slot > 0) && ((sh >> (4 * slot)) == 16'h0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Reference: slot = which digit by elapsed time, pos = cycle within slot.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_k = 0; m_shadow = 16'h0; m_pend_val = 16'h0; m_pend_v = 1'b0;
      e_an = 4'hF; e_seg = 7'h7F; e_fs = 1'b0;
    end else begin
      int slot;
      int pos;
      bit vis;
      logic [3:0] nb;
      slot = (m_k / R) % N;
      pos  = m_k % R;
      vis  = (pos >= B) && digit_en[slot] && !lz_dark(m_shadow, slot);
      nb   = m_shadow[4*slot +: 4];
      e_an  = vis ? ~(4'b0001 << slot) : 4'hF;
      e_seg = vis ? DEC[nb] : 7'h7F;
      e_fs  = (pos == R - 1) && (slot == N - 1);
      if (e_fs && m_pend_v) begin
        m_shadow = m_pend_val;
        m_pend_v = 1'b0;
      end
      if (load) begin
        m_pend_val = data;
        m_pend_v   = 1'b1;
      end
      m_k++;
    end
  end

  // Per-cycle compare against the reference.
  always @(negedge clk) begin
    check("an", 32'(an), 32'(e_an));
    check("seg", 32'(seg), 32'(e_seg));
    check("pending", 32'(pending), 32'(m_pend_v));
    check("frame_start", 32'(frame_start), 32'(e_fs));
  end

  task automatic step(int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_fs(string nm);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 80; i++) begin
      step(1);
      if (frame_start) begin
        found = 1'b1;
        break;
      end
    end
    n_chk++;
    if (found) n_pass++;
    else $display("FAIL %s: frame_start not seen within 80 cycles (got 0, need 1)", nm);
  endtask

  task automatic load_word(logic [15:0] w);
    data = w;
    load = 1'b1;
    step(1);
    load = 1'b0;
  endtask

  initial begin
    // Reset held with a load attempt: nothing must be captured.
    rst_n = 1'b0; data = 16'h1234; load = 1'b1;
    step(3);
    check("rst_an", 32'(an), 32'h0000000F);
    check("rst_seg", 32'(seg), 32'h0000007F);
    check("rst_pending", 32'(pending), 32'h0);
    load = 1'b0;
    rst_n = 1'b1;
    step(1);
    check("post_rst_blank", 32'(an), 32'h0000000F);
    step(2);
    check("post_rst_d0_an", 32'(an), 32'(4'b1110));
    check("post_rst_d0_seg", 32'(seg), 32'(7'b1000000));

    // Basic load and full-frame sequence.
    load_word(16'h12AF);
    check("load_pending", 32'(pending), 32'h1);
    wait_fs("fs_12af");
    check("commit_pending", 32'(pending), 32'h0);
    step(1);
    check("slot0_gap_an", 32'(an), 32'h0000000F);
    step(2);
    check("s0_an", 32'(an), 32'(4'b1110));
    check("s0_seg", 32'(seg), 32'(7'b0001110));
    step(8);
    check("s1_an", 32'(an), 32'(4'b1101));
    check("s1_seg", 32'(seg), 32'(7'b0001000));
    step(8);
    check("s2_an", 32'(an), 32'(4'b1011));
    check("s2_seg", 32'(seg), 32'(7'b0100100));
    step(8);
    check("s3_an", 32'(an), 32'(4'b0111));
    check("s3_seg", 32'(seg), 32'(7'b1111001));

    // Two loads in one frame: only the last one is shown.
    wait_fs("sync_a");
    step(5);
    load_word(16'h1111);
    step(9);
    load_word(16'h2222);
    wait_fs("fs_2222");
    check("latest_pending", 32'(pending), 32'h0);
    step(3);
    check("latest_s0_seg", 32'(seg), 32'(7'b0100100));
    step(24);
    check("latest_s3_an", 32'(an), 32'(4'b0111));
    check("latest_s3_seg", 32'(seg), 32'(7'b0100100));

    // Load coincident with the wrapping tick.
    wait_fs("sync_b");
    load_word(16'h3333);
    step(30);
    data = 16'h4444; load = 1'b1;
    step(1);
    load = 1'b0;
    check("wrap_fs", 32'(frame_start), 32'h1);
    check("wrap_pending", 32'(pending), 32'h1);
    step(3);
    check("wrap_old_seg", 32'(seg), 32'(7'b0110000));
    wait_fs("fs_4444");
    check("wrap_new_pending", 32'(pending), 32'h0);
    step(3);
    check("wrap_new_seg", 32'(seg), 32'(7'b0011001));

    // Leading-zero handling for 0050 and 0000.
    load_word(16'h0050);
    wait_fs("fs_0050");
    step(3);
    check("z50_d0_an", 32'(an), 32'(4'b1110));
    check("z50_d0_seg", 32'(seg), 32'(7'b1000000));
    step(8);
    check("z50_d1_an", 32'(an), 32'(4'b1101));
    check("z50_d1_seg", 32'(seg), 32'(7'b0010010));
    step(8);
`ifdef SEG7_LZB_EN
    check("z50_d2_an", 32'(an), 32'h0000000F);
    step(8);
    check("z50_d3_an", 32'(an), 32'h0000000F);
`else
    check("z50_d2_an", 32'(an), 32'(4'b1011));
    step(8);
    check("z50_d3_an", 32'(an), 32'(4'b0111));
    check("z50_d3_seg", 32'(seg), 32'(7'b1000000));
`endif
    load_word(16'h0000);
    wait_fs("fs_0000");
    step(3);
    check("z0_d0_an", 32'(an), 32'(4'b1110));
    check("z0_d0_seg", 32'(seg), 32'(7'b1000000));
    step(8);
`ifdef SEG7_LZB_EN
    check("z0_d1_an", 32'(an), 32'h0000000F);
`else
    check("z0_d1_an", 32'(an), 32'(4'b1101));
`endif

    // Per-digit enable with 8888.
    digit_en = 4'b1010;
    load_word(16'h8888);
    wait_fs("fs_8888");
    begin
      int bad;
      bad = 0;
      for (int i = 1; i <= 32; i++) begin
        step(1);
        if (an[0] == 1'b0 || an[2] == 1'b0) bad++;
        if (i == 11) begin
          check("en_d1_an", 32'(an), 32'(4'b1101));
          check("en_d1_seg", 32'(seg), 32'(7'b0000000));
        end
        if (i == 27) begin
          check("en_d3_an", 32'(an), 32'(4'b0111));
          check("en_d3_seg", 32'(seg), 32'(7'b0000000));
        end
      end
      check("en_dark_cycles", 32'(bad), 32'h0);
    end
    digit_en = 4'hF;

    // Mid-frame asynchronous reset discards pending data.
    step(13);
    load_word(16'h9ABC);
    step(2);
    rst_n = 1'b0;
    #1;
    check("async_an", 32'(an), 32'h0000000F);
    check("async_seg", 32'(seg), 32'h0000007F);
    check("async_pending", 32'(pending), 32'h0);
    step(2);
    rst_n = 1'b1;

    // Random traffic against the reference.
    for (int c = 0; c < 3000; c++) begin
      load = ($urandom_range(0, 11) == 0);
      data = 16'($urandom);
      if ($urandom_range(0, 39) == 0) digit_en = 4'($urandom);
      if ($urandom_range(0, 599) == 0) begin
        rst_n = 1'b0;
        #1;
        check("rand_async_an", 32'(an), 32'h0000000F);
        step(2);
        rst_n = 1'b1;
      end
      step(1);
    end
    load = 1'b0;
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
